// File: rtl/tilt_pkg.sv
// Shared tilt/ball definitions: one-hot direction codes and decode FSM states.
package tilt_pkg;
  typedef logic [3:0] dir_t;

  localparam dir_t IDLE  = 4'b0000;
  localparam dir_t UP    = 4'b0001;
  localparam dir_t DOWN  = 4'b0010;
  localparam dir_t LEFT  = 4'b0100;
  localparam dir_t RIGHT = 4'b1000;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_DECODE = 1'b1
  } tilt_state_e;
endpackage

// File: rtl/tilt_move_gen_if.sv
// Sensor-to-decoder bus: signed accel samples in, movement/update out.
interface tilt_move_gen_if #(parameter int ACCEL_WIDTH = 12);
  import tilt_pkg::*;

  logic signed [ACCEL_WIDTH-1:0] accel_x;
  logic signed [ACCEL_WIDTH-1:0] accel_y;
  logic                          accel_valid;
  dir_t                          movement;
  logic                          update;

  modport master (output accel_x, accel_y, accel_valid, input movement, update);
  modport slave  (input accel_x, accel_y, accel_valid, output movement, update);
endinterface

// File: rtl/tilt_move_gen_tick_gen.sv
// Update tick divider: one-cycle pulse every PERIOD clocks, registered output.
module tick_gen #(
  parameter int PERIOD = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/tilt_move_gen.sv
// Tilt decoder: averages 2^AVG_SHIFT-sample windows, decodes a one-hot direction and
// presents it in step with the update tick. TILT_HYSTERESIS_EN enables direction hold.
module tilt_move_gen
  import tilt_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 30,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  parameter int ACCEL_WIDTH            = 12,
  parameter int AVG_SHIFT              = 2,
  parameter int DEADZONE               = 64,
  parameter int STALE_TICKS            = 8
) (
  input logic            clk,
  input logic            reset,
  tilt_move_gen_if.slave bus
);
  localparam int N_SAMP     = 1 << AVG_SHIFT;
  localparam int ACC_W      = ACCEL_WIDTH + AVG_SHIFT;
  localparam int CNT_W      = AVG_SHIFT + 1;
  localparam int STALE_W    = $clog2(STALE_TICKS + 1);
  localparam int DIV_PERIOD = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                              : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
  localparam logic [ACC_W:0]       MAG_MAX   = (ACC_W+1)'((1 << (ACCEL_WIDTH-1)) - 1);
  localparam logic [ACCEL_WIDTH:0] DZ        = (ACCEL_WIDTH+1)'(DEADZONE);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(N_SAMP - 1);
  localparam logic [STALE_W-1:0]   STALE_MAX = STALE_W'(STALE_TICKS);
`ifdef TILT_HYSTERESIS_EN
  localparam logic [ACCEL_WIDTH:0] HALF      = (ACCEL_WIDTH+1)'(DEADZONE >> 1);
`endif

  tilt_state_e               state_q, state_d;
  logic [1:0][ACC_W-1:0]     acc_q, acc_d, samp;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [STALE_W-1:0]        stale_q, stale_d;
  dir_t                      pending_q, pending_d, mov_q, mov_d, dec_dir;
  logic [ACCEL_WIDTH:0]      mag_x, mag_y;
  logic                      neg_x, neg_y, tick;

  tick_gen #(.PERIOD(DIV_PERIOD)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  // |sum >>> AVG_SHIFT|, clamped so the most negative average still fits as a positive value.
  function automatic logic [ACCEL_WIDTH:0] mag_of(input logic [ACC_W-1:0] sum);
    logic signed [ACC_W:0] avg;
    logic        [ACC_W:0] abs_v;
    avg   = $signed({sum[ACC_W-1], sum}) >>> AVG_SHIFT;
    abs_v = avg[ACC_W] ? $unsigned(-avg) : $unsigned(avg);
    if (abs_v > MAG_MAX) abs_v = MAG_MAX;
    return (ACCEL_WIDTH+1)'(abs_v);
  endfunction

  assign samp = {ACC_W'(bus.accel_y), ACC_W'(bus.accel_x)};

  always_comb begin
    mag_x   = mag_of(acc_q[0]);
    mag_y   = mag_of(acc_q[1]);
    neg_x   = acc_q[0][ACC_W-1];
    neg_y   = acc_q[1][ACC_W-1];
    dec_dir = IDLE;
    if (mag_x > DZ || mag_y > DZ)
      dec_dir = (mag_x >= mag_y) ? (neg_x ? DOWN : UP) : (neg_y ? LEFT : RIGHT);
`ifdef TILT_HYSTERESIS_EN
    // Hold while the active axis stays past half the deadzone unless the other axis clearly takes over.
    case (pending_q)
      UP:      if (!neg_x && mag_x > HALF && !(mag_y > DZ && mag_y > mag_x)) dec_dir = UP;
      DOWN:    if ( neg_x && mag_x > HALF && !(mag_y > DZ && mag_y > mag_x)) dec_dir = DOWN;
      LEFT:    if ( neg_y && mag_y > HALF && !(mag_x > DZ && mag_x > mag_y)) dec_dir = LEFT;
      RIGHT:   if (!neg_y && mag_y > HALF && !(mag_x > DZ && mag_x > mag_y)) dec_dir = RIGHT;
      default: ;
    endcase
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    stale_d   = stale_q;
    mov_d     = tick ? pending_q : mov_q;

    // A sample arriving with the expiring tick wins: counter clears, pending untouched.
    if (bus.accel_valid) begin
      stale_d = '0;
    end else if (tick && stale_q != STALE_MAX) begin
      stale_d = stale_q + STALE_W'(1);
      if (stale_d == STALE_MAX) pending_d = IDLE;
    end

    case (state_q)
      ST_ACCUM: begin
        if (bus.accel_valid) begin
          acc_d[0] = acc_q[0] + samp[0];
          acc_d[1] = acc_q[1] + samp[1];
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DECODE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DECODE: begin
        pending_d = dec_dir;
        state_d   = ST_ACCUM;
        acc_d     = bus.accel_valid ? samp : '0;
        cnt_d     = bus.accel_valid ? CNT_W'(1) : '0;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      stale_q   <= '0;
      pending_q <= IDLE;
      mov_q     <= IDLE;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      stale_q   <= stale_d;
      pending_q <= pending_d;
      mov_q     <= mov_d;
    end
  end

  assign bus.movement = mov_q;
  assign bus.update   = tick;
endmodule

// File: tb/tb_tilt_move_gen.sv
// Bench for tilt_move_gen: directed scenarios plus randomized samples, all outputs compared
// every cycle against a window-list/arithmetic reference model.
`timescale 1ns/1ps
module tb_tilt_move_gen;
  import tilt_pkg::*;

  localparam int AW = 12, SH = 2, NW = 1 << SH, DZ = 64, STALE = 8, PER = 5, MAGMAX = 2047;
`ifdef TILT_HYSTERESIS_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  int   n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  tilt_move_gen_if #(.ACCEL_WIDTH(AW)) bus ();

  tilt_move_gen #(
    .CLK_FREQUENCY_HZ(100000000), .UPDATE_FREQUENCY_HZ(30), .SIMULATE(1),
    .SIMULATE_FREQUENCY_CNT(PER), .ACCEL_WIDTH(AW), .AVG_SHIFT(SH),
    .DEADZONE(DZ), .STALE_TICKS(STALE)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         qx[$], qy[$];
  bit         m_full = 1'b0, m_upd = 1'b0;
  int         m_edges = 0, m_stale = 0;
  logic [3:0] m_pend = IDLE, m_mov = IDLE, m_nmov, m_prev;

  function automatic int fdiv(input int s);
    return (s >= 0) ? s / NW : -((-s + NW - 1) / NW);
  endfunction

  function automatic int mag(input int a);
    int m;
    m = (a < 0) ? -a : a;
    return (m > MAGMAX) ? MAGMAX : m;
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic logic [3:0] ref_dir(input int sx, input int sy, input logic [3:0] prev);
    int ax, ay, mx, my;
    ax = fdiv(sx); ay = fdiv(sy); mx = mag(ax); my = mag(ay);
    if (HYST) begin
      if (prev == UP    && ax > 0 && mx > DZ/2 && !(my > DZ && my > mx)) return UP;
      if (prev == DOWN  && ax < 0 && mx > DZ/2 && !(my > DZ && my > mx)) return DOWN;
      if (prev == LEFT  && ay < 0 && my > DZ/2 && !(mx > DZ && mx > my)) return LEFT;
      if (prev == RIGHT && ay > 0 && my > DZ/2 && !(mx > DZ && mx > my)) return RIGHT;
    end
    if (mx <= DZ && my <= DZ) return IDLE;
    if (mx >= my) return (ax > 0) ? UP : DOWN;
    return (ay < 0) ? LEFT : RIGHT;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      qx.delete(); qy.delete();
      m_full = 1'b0; m_upd = 1'b0; m_edges = 0; m_stale = 0;
      m_pend = IDLE; m_mov = IDLE;
    end else begin
      m_nmov = m_upd ? m_pend : m_mov;
      m_prev = m_pend;
      if (bus.accel_valid) m_stale = 0;
      else if (m_upd && m_stale < STALE) begin
        m_stale++;
        if (m_stale == STALE) m_pend = IDLE;
      end
      if (m_full) begin
        m_pend = ref_dir(qsum(qx), qsum(qy), m_prev);
        qx.delete(); qy.delete();
        m_full = 1'b0;
        if (bus.accel_valid) begin
          qx.push_back(int'(bus.accel_x)); qy.push_back(int'(bus.accel_y));
        end
      end else if (bus.accel_valid) begin
        qx.push_back(int'(bus.accel_x)); qy.push_back(int'(bus.accel_y));
        m_full = (qx.size() == NW);
      end
      m_mov   = m_nmov;
      m_edges++;
      m_upd   = (m_edges % PER == 0);
    end
  end

  // ---------------- per-cycle checker ----------------
  logic [3:0] prev_mov = IDLE;
  bit         prev_upd = 1'b0, prev_rst = 1'b0;

  initial forever begin
    @(negedge clk);
    chk("movement", 32'(bus.movement), 32'(m_mov));
    chk("update", 32'(bus.update), 32'(m_upd));
    if (reset && prev_rst && bus.movement !== prev_mov)
      chk("mov_after_update", 32'(prev_upd), 32'd1);
    prev_mov = bus.movement; prev_upd = bus.update; prev_rst = reset;
  end

  // ---------------- stimulus ----------------
  task automatic send(input int x, input int y);
    @(negedge clk);
    bus.accel_valid = 1'b1; bus.accel_x = AW'(x); bus.accel_y = AW'(y);
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.accel_valid = 1'b0;
  endtask

  // Called in the cycle after a window's last sample; returns once movement has reloaded.
  task automatic wait_move();
    int k = 0;
    @(negedge clk);
    while (bus.update !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("update_timeout", 32'(bus.update), 32'd1);
    @(negedge clk);
  endtask

  task automatic win(input int x, input int y);
    repeat (NW) send(x, y);
    idle_in();
    wait_move();
  endtask

  function automatic logic [AW-1:0] rnd_samp();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, 4095));
      1:       return AW'(int'($urandom_range(0, 300)) - 150);
      2:       return ($urandom_range(0, 1) != 0) ? 12'h800 : 12'h7FF;
      default: return AW'(int'($urandom_range(0, 60)) - 30);
    endcase
  endfunction

  initial begin
    int ups;
    bus.accel_valid = 1'b0; bus.accel_x = '0; bus.accel_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_movement", 32'(bus.movement), 32'(IDLE));
    chk("reset_update", 32'(bus.update), 32'd0);
    #2 reset = 1'b1;

    ups = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.update === 1'b1) ups++;
    end
    chk("tick_count", 32'(ups), 32'd10);

    win(200, 10);   chk("dec_up",        32'(bus.movement), 32'(UP));
    win(100, -100); chk("dec_tie_x",     32'(bus.movement), 32'(UP));
    win(-5, -300);  chk("dec_left",      32'(bus.movement), 32'(LEFT));
    win(-1, 0);     chk("avg_minus_one", 32'(bus.movement), 32'(IDLE));
    win(64, -64);   chk("dec_deadzone",  32'(bus.movement), 32'(IDLE));

    send(0, 0); send(0, 0); send(0, 0); send(400, 0); idle_in(); wait_move();
    chk("avg_0004", 32'(bus.movement), 32'(UP));

    repeat (NW) send(-200, 0);
    repeat (NW) send(200, 0);
    idle_in(); wait_move();
    chk("valid_in_decode", 32'(bus.movement), 32'(UP));

    win(100, 0); chk("hyst_start", 32'(bus.movement), 32'(UP));
    win(40, 0);  chk("hyst_40",    32'(bus.movement), 32'(HYST ? UP : IDLE));
    win(30, 0);  chk("hyst_30",    32'(bus.movement), 32'(IDLE));

    win(200, 0); chk("stale_start", 32'(bus.movement), 32'(UP));
    repeat (30) @(negedge clk);
    chk("stale_hold", 32'(bus.movement), 32'(UP));
    repeat (30) @(negedge clk);
    chk("stale_idle", 32'(bus.movement), 32'(IDLE));
    win(200, 0); chk("stale_recover", 32'(bus.movement), 32'(UP));

    send(200, 0); send(200, 0); idle_in();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_mov", 32'(bus.movement), 32'(IDLE));
    chk("async_reset_upd", 32'(bus.update), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    send(200, 0); send(200, 0); idle_in(); wait_move();
    chk("partial_discard", 32'(bus.movement), 32'(IDLE));
    send(200, 0); send(200, 0); idle_in(); wait_move();
    chk("fresh_window", 32'(bus.movement), 32'(UP));

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.accel_valid = ($urandom_range(0, 99) < ((i < 900) ? 70 : 4));
      bus.accel_x = rnd_samp();
      bus.accel_y = rnd_samp();
    end
    @(negedge clk);
    bus.accel_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog timeout");
  end
endmodule
